// File: rtl/ex_muldiv_if.sv
// Request/response bundle between the execute stage and the iterative mul/div unit.
// The master side issues operations; the slave side is the unit itself.
interface ex_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start_i;
  logic [2:0]           op_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic [WIDTH-1:0]     hi_i;
  logic [WIDTH-1:0]     lo_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
    input  result_o, ready_o, busy_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, hi_i, lo_i, annul_i,
    output result_o, ready_o, busy_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative radix-2 multiply/divide/accumulate unit producing a {HI, LO} result.
// One shared 2*WIDTH shift register serves both the shift-add and the restoring divide.
module ex_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  ex_muldiv_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StAcc, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   hilo_q, hilo_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 neg_x_q, neg_x_d;
  logic                 neg_r_q, neg_r_d;
  logic                 ready_q, busy_q;

  logic                 s1, s2, is_div_in, is_div_q;
  logic [WIDTH-1:0]     mag1, mag2, fix_hi, fix_lo;
  logic [WIDTH:0]       mul_sum, div_rs, div_diff;
  logic [2*WIDTH-1:0]   step, fix_src, fixed, acc_out;

  // Operand capture helpers
  always_comb begin
    s1        = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    s2        = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    mag1      = s1 ? -bus.opdata1_i : bus.opdata1_i;
    mag2      = s2 ? -bus.opdata2_i : bus.opdata2_i;
    is_div_in = (bus.op_i[2:1] == 2'b01);
    is_div_q  = (op_q[2:1] == 2'b01);
  end

  // One iteration: multiply keeps the multiplier in LO and shifts right; divide shifts
  // {rem, quot} left and restores when the trial subtraction goes negative.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_rs   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rs - {1'b0, opb_q};
    if (is_div_q) begin
      if (div_diff[WIDTH]) step = {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the final magnitude result, then optional accumulate
  always_comb begin
    fix_src = (state_q == StAcc) ? acc_q : step;
    fix_hi  = fix_src[2*WIDTH-1:WIDTH];
    fix_lo  = fix_src[WIDTH-1:0];
    if (is_div_q) fixed = {neg_r_q ? -fix_hi : fix_hi, neg_x_q ? -fix_lo : fix_lo};
    else          fixed = neg_x_q ? -fix_src : fix_src;
    acc_out = op_q[1] ? (hilo_q - fixed) : (hilo_q + fixed);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    hilo_d   = hilo_q;
    neg_x_d  = neg_x_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    if (bus.annul_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            op_d    = bus.op_i;
            opb_d   = is_div_in ? mag2 : mag1;
            acc_d   = {{WIDTH{1'b0}}, is_div_in ? mag1 : mag2};
            hilo_d  = {bus.hi_i, bus.lo_i};
            neg_x_d = s1 ^ s2;
            neg_r_d = s1;
            cnt_d   = CntW'(WIDTH - 1);
            if (is_div_in && (bus.opdata2_i == '0)) begin
              state_d  = StDone;
              result_d = {bus.opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          acc_d = step;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            if (op_q[2]) begin
              state_d = StAcc;
            end else begin
              state_d  = StDone;
              result_d = fixed;
            end
          end
        end
        StAcc: begin
          state_d  = StDone;
          result_d = acc_out;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      hilo_q   <= '0;
      neg_x_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      hilo_q   <= hilo_d;
      neg_x_q  <= neg_x_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      ready_q  <= (state_d == StDone);
      busy_q   <= (state_d == StRun) || (state_d == StAcc);
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: stimulus pushes expected {result, due cycle},
// monitors pop and compare on every ready_o pulse.
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) bus ();
  ex_muldiv_if #(.WIDTH(8))  bus8 ();

  ex_muldiv #(.WIDTH(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  ex_muldiv #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [63:0] exp_res_q[$];
  int          exp_due_q[$];
  int          exp_id_q[$];
  logic [15:0] exp8_res_q[$];
  int          exp8_due_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // 32-bit monitor
  always @(negedge clk) begin
    if (rst && bus.ready_o) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected ready_o", 64'd1, 64'd0);
      end else begin
        automatic logic [63:0] r = exp_res_q.pop_front();
        automatic int d = exp_due_q.pop_front();
        automatic int id = exp_id_q.pop_front();
        check($sformatf("op%0d result", id), bus.result_o, r);
        check($sformatf("op%0d ready cycle", id), 64'(cyc), 64'(d));
      end
    end
  end

  // 8-bit monitor
  always @(negedge clk) begin
    if (rst && bus8.ready_o) begin
      if (exp8_res_q.size() == 0) begin
        check("w8 unexpected ready_o", 64'd1, 64'd0);
      end else begin
        automatic logic [15:0] r = exp8_res_q.pop_front();
        automatic int d = exp8_due_q.pop_front();
        check("w8 result", 64'(bus8.result_o), 64'(r));
        check("w8 ready cycle", 64'(cyc), 64'(d));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                       input logic [63:0] exp, input int lat, input bit push);
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.hi_i      = hi;
    bus.lo_i      = lo;
    bus.start_i   = 1'b1;
    if (push) begin
      exp_res_q.push_back(exp);
      exp_due_q.push_back(cyc + lat);
      exp_id_q.push_back(id);
    end
    @(posedge clk);
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
  endtask

  task automatic issue8(input logic [2:0] op, input logic [7:0] a, b,
                        input logic [15:0] exp, input int lat);
    bus8.op_i      = op;
    bus8.opdata1_i = a;
    bus8.opdata2_i = b;
    bus8.start_i   = 1'b1;
    exp8_res_q.push_back(exp);
    exp8_due_q.push_back(cyc + lat);
    @(posedge clk);
    @(negedge clk);
    bus8.start_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.start_i = 1'b0;  bus.op_i = '0;  bus.opdata1_i = '0;  bus.opdata2_i = '0;
    bus.hi_i = '0;  bus.lo_i = '0;  bus.annul_i = 1'b0;
    bus8.start_i = 1'b0; bus8.op_i = '0; bus8.opdata1_i = '0; bus8.opdata2_i = '0;
    bus8.hi_i = '0; bus8.lo_i = '0; bus8.annul_i = 1'b0;
    #12;
    check("reset result_o", bus.result_o, 64'd0);
    check("reset ready_o", 64'(bus.ready_o), 64'd0);
    check("reset busy_o", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Each op is followed by idle(lat): next issue lands in the IDLE cycle right after DONE.
    issue(1, 3'b001, 32'hFFFF_FFFE, 32'h3, 0, 0, 64'hFFFF_FFFF_FFFF_FFFA, 33, 1'b1);
    check("busy_o during RUN", 64'(bus.busy_o), 64'd1);
    idle(33);
    issue(2, 3'b000, 32'hFFFF_FFFE, 32'h3, 0, 0, 64'h0000_0002_FFFF_FFFA, 33, 1'b1);
    idle(33);
    issue(3, 3'b011, 32'hFFFF_FFF9, 32'h2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 33, 1'b1);
    idle(33);
    issue(4, 3'b010, 32'd100, 32'd7, 0, 0, 64'h0000_0002_0000_000E, 33, 1'b1);
    idle(33);
    issue(5, 3'b010, 32'd5, 32'd0, 0, 0, 64'h0000_0005_FFFF_FFFF, 1, 1'b1);
    check("busy_o on divide by zero", 64'(bus.busy_o), 64'd0);
    idle(1);
    issue(6, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 64'h0000_0000_8000_0000, 33, 1'b1);
    idle(33);
    issue(7, 3'b101, 32'd3, 32'hFFFF_FFFC, 32'd0, 32'd10, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b1);
    idle(34);
    issue(8, 3'b110, 32'd1, 32'd1, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b1);
    idle(34);
    issue(9, 3'b000, 32'd7, 32'd6, 0, 0, 64'd42, 33, 1'b1);
    idle(33);

    // Annul in RUN: no pulse, result holds 42
    issue(10, 3'b001, 32'd5, 32'd5, 0, 0, 64'd0, 0, 1'b0);
    idle(4);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("busy_o after annul", 64'(bus.busy_o), 64'd0);
    check("result_o after annul", bus.result_o, 64'd42);
    idle(40);

    // Annul together with start in IDLE: start dropped
    bus.annul_i = 1'b1;
    issue(11, 3'b000, 32'd2, 32'd2, 0, 0, 64'd0, 0, 1'b0);
    bus.annul_i = 1'b0;
    check("busy_o after annul+start", 64'(bus.busy_o), 64'd0);
    idle(40);
    check("result_o after annul+start", bus.result_o, 64'd42);

    // Start pulsed during RUN is ignored
    issue(12, 3'b010, 32'd100, 32'd7, 0, 0, 64'h0000_0002_0000_000E, 33, 1'b1);
    idle(9);
    bus.op_i = 3'b000; bus.opdata1_i = 32'd1; bus.opdata2_i = 32'd1; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    idle(40);

    // Reset mid-DIV clears outputs asynchronously; no pulse afterwards
    issue(13, 3'b011, 32'd1000, 32'd3, 0, 0, 64'd0, 0, 1'b0);
    idle(10);
    #2 rst = 1'b0;
    #1;
    check("async reset result_o", bus.result_o, 64'd0);
    check("async reset ready_o", 64'(bus.ready_o), 64'd0);
    check("async reset busy_o", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(40);
    check("result_o after reset release", bus.result_o, 64'd0);

    // WIDTH=8 instance
    issue8(3'b001, 8'hFE, 8'h03, 16'hFFFA, 9);
    idle(9);
    issue8(3'b000, 8'hFE, 8'h03, 16'h02FA, 9);
    idle(12);

    check("pending 32-bit results", 64'(exp_res_q.size()), 64'd0);
    check("pending 8-bit results", 64'(exp8_res_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
